// File: rtl/drop_sched_pkg.sv
// Shared types, default tick constants and the level-to-period helper for drop_scheduler.
package drop_sched_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, REQ} state_t;

    localparam int unsigned DEF_CNT_W      = 25;
    localparam int unsigned DEF_BASE_TICKS = 12_500_000;
    localparam int unsigned DEF_STEP_TICKS = 625_000;
    localparam int unsigned DEF_MIN_TICKS  = 1_250_000;
    localparam int unsigned DEF_SOFT_TICKS = 625_000;
    localparam int unsigned DEF_LOCK_TICKS = 12_500_000;

    // Reduction is compared against base first so the subtraction can never wrap.
    function automatic logic [31:0] period_for_level(
        input logic [3:0]  lvl,
        input logic [31:0] base_ticks,
        input logic [31:0] step_ticks,
        input logic [31:0] min_ticks
    );
        logic [31:0] reduction;
        logic [31:0] diff;
        reduction = 32'(lvl) * step_ticks;
        if (reduction >= base_ticks) begin
            return min_ticks;
        end
        diff = base_ticks - reduction;
        return (diff < min_ticks) ? min_ticks : diff;
    endfunction

endpackage

// File: rtl/drop_scheduler_lock_timer.sv
// Lock-delay counter: one pulse per landing after LOCK_TICKS unpaused landed cycles.
module lock_timer
    import drop_sched_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned LOCK_TICKS = DEF_LOCK_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic pause,
    input  logic restart,
    input  logic landed,
    output logic lock_pulse
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;

    // Re-arming only on landed low keeps a resting piece from pulsing repeatedly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_armed    <= 1'b1;
            lock_pulse <= 1'b0;
        end else begin
            lock_pulse <= 1'b0;
            if (!landed || !en || restart) begin
                r_cnt <= '0;
                if (!landed) begin
                    r_armed <= 1'b1;
                end
            end else if (!pause && r_armed) begin
                if (r_cnt == LOCK_LAST) begin
                    lock_pulse <= 1'b1;
                    r_cnt      <= '0;
                    r_armed    <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/drop_scheduler.sv
// Gravity/drop timing controller with req/ack handshake to the game FSM.
// Optional lock delay enabled by defining DROP_SCHED_LOCK_DELAY_EN.
module drop_scheduler
    import drop_sched_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned BASE_TICKS = DEF_BASE_TICKS,
    parameter int unsigned STEP_TICKS = DEF_STEP_TICKS,
    parameter int unsigned MIN_TICKS  = DEF_MIN_TICKS,
    parameter int unsigned SOFT_TICKS = DEF_SOFT_TICKS,
    parameter int unsigned LOCK_TICKS = DEF_LOCK_TICKS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pause,
    input  logic [3:0] level,
    input  logic       soft_drop,
    input  logic       restart,
    input  logic       drop_ack,
    input  logic       landed,
    output logic       drop_req,
    output logic       lock_pulse,
    output logic       active
);

    localparam logic [CNT_W-1:0] SOFT_W = CNT_W'(SOFT_TICKS);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic [3:0]       r_lvl;
    logic [3:0]       w_next_lvl;
    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_target;

    assign w_period = CNT_W'(period_for_level(r_lvl, 32'(BASE_TICKS), 32'(STEP_TICKS), 32'(MIN_TICKS)));
    assign w_target = (soft_drop && (SOFT_W < w_period)) ? SOFT_W : w_period;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_next_lvl   = r_lvl;
        if (!en) begin
            w_next_state = IDLE;
            w_next_cnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_next_state = COUNT;
                    w_next_cnt   = '0;
                    w_next_lvl   = level;
                end
                COUNT: begin
                    if (restart) begin
                        w_next_cnt = '0;
                        w_next_lvl = level;
                    end else if (!pause) begin
                        if (r_cnt >= w_target - 1'b1) begin
                            w_next_state = REQ;
                        end else begin
                            w_next_cnt = r_cnt + 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (restart || drop_ack) begin
                        w_next_state = COUNT;
                        w_next_cnt   = '0;
                        w_next_lvl   = level;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_lvl    <= '0;
            drop_req <= 1'b0;
            active   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            r_lvl    <= w_next_lvl;
            drop_req <= (w_next_state == REQ);
            active   <= (w_next_state != IDLE);
        end
    end

`ifdef DROP_SCHED_LOCK_DELAY_EN
    lock_timer #(
        .CNT_W     (CNT_W),
        .LOCK_TICKS(LOCK_TICKS)
    ) u_lock_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pause     (pause),
        .restart   (restart),
        .landed    (landed),
        .lock_pulse(lock_pulse)
    );
`else
    logic w_unused_landed;
    assign w_unused_landed = landed;
    assign lock_pulse      = 1'b0;
`endif

endmodule

// File: tb/tb_drop_scheduler.sv
// Randomized self-checking bench for drop_scheduler against an interval-level reference model.
module tb_drop_scheduler;

    localparam int BASE = 20;
    localparam int STEP = 2;
    localparam int MIN  = 4;
    localparam int SOFT = 3;
    localparam int LOCK = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] level = 4'd0;
    logic       soft_drop = 1'b0;
    logic       restart = 1'b0;
    logic       drop_ack = 1'b0;
    logic       landed = 1'b0;
    logic       drop_req;
    logic       lock_pulse;
    logic       active;

    int vectorCount = 0;
    int missCount   = 0;
    int cycle       = 0;

    bit mIdle = 1'b1;
    bit mReq = 1'b0;
    int mElapsed = 0;
    int mLvl = 0;
    bit mPulse = 1'b0;
    bit mArmed = 1'b1;
    int mLockCnt = 0;

    drop_scheduler #(
        .CNT_W(25), .BASE_TICKS(BASE), .STEP_TICKS(STEP),
        .MIN_TICKS(MIN), .SOFT_TICKS(SOFT), .LOCK_TICKS(LOCK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .level(level),
        .soft_drop(soft_drop), .restart(restart), .drop_ack(drop_ack),
        .landed(landed), .drop_req(drop_req), .lock_pulse(lock_pulse), .active(active)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed != expected) begin
            missCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
        end
    endtask

    function automatic void modelReset();
        mIdle = 1'b1; mReq = 1'b0; mElapsed = 0; mLvl = 0;
        mPulse = 1'b0; mArmed = 1'b1; mLockCnt = 0;
    endfunction

    // One clock of the game-level rules: a drop is due once target unpaused cycles have elapsed.
    function automatic void modelStep();
        int period;
        int target;
        if (!rst_n) begin
            modelReset();
            return;
        end
        period = BASE - mLvl * STEP;
        if (period < MIN) period = MIN;
        target = (soft_drop && SOFT < period) ? SOFT : period;
        mPulse = 1'b0;
`ifdef DROP_SCHED_LOCK_DELAY_EN
        if (!landed || !en || restart) begin
            mLockCnt = 0;
            if (!landed) mArmed = 1'b1;
        end else if (!pause && mArmed) begin
            mLockCnt++;
            if (mLockCnt == LOCK) begin
                mPulse = 1'b1; mLockCnt = 0; mArmed = 1'b0;
            end
        end
`endif
        if (!en) begin
            mIdle = 1'b1; mReq = 1'b0; mElapsed = 0;
        end else if (mIdle || restart || (mReq && drop_ack)) begin
            mIdle = 1'b0; mReq = 1'b0; mElapsed = 0; mLvl = int'(level);
        end else if (!mReq && !pause) begin
            if (mElapsed + 1 >= target) mReq = 1'b1;
            else mElapsed++;
        end
    endfunction

    task automatic applyStimulus(input bit e, input bit p, input bit s, input bit r,
                                 input bit a, input bit l, input logic [3:0] lv);
        @(negedge clk);
        en = e; pause = p; soft_drop = s; restart = r; drop_ack = a; landed = l; level = lv;
        @(posedge clk);
        cycle++;
        modelStep();
        #1;
        checkOutput("drop_req", int'(drop_req), int'(mReq));
        checkOutput("active", int'(active), int'(!mIdle));
        checkOutput("lock_pulse", int'(lock_pulse), int'(mPulse));
    endtask

    // Ack held high: spacing of successive drop_req rises equals target + 1.
    task automatic measureGap(input string tag, input logic [3:0] lv, input bit s, input int expGap);
        int rises[$];
        bit prev;
        prev = drop_req;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b1, 1'b0, s, 1'b0, 1'b1, 1'b0, lv);
            if (drop_req && !prev) rises.push_back(cycle);
            prev = drop_req;
        end
        if (rises.size() >= 3) checkOutput(tag, rises[rises.size()-1] - rises[rises.size()-2], expGap);
        else checkOutput({tag, "_count"}, rises.size(), 3);
    endtask

    initial begin
        bit waitOk;
        bit rEn, rPause, rSoft, rRestart, rAck, rLanded;
        logic [3:0] rLevel;

        modelReset();
        #1;
        checkOutput("reset_drop_req", int'(drop_req), 0);
        checkOutput("reset_active", int'(active), 0);
        checkOutput("reset_lock_pulse", int'(lock_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;

        measureGap("gap_level0", 4'd0, 1'b0, 21);
        measureGap("gap_level9", 4'd9, 1'b0, 5);
        measureGap("gap_level5", 4'd5, 1'b0, 11);
        measureGap("gap_soft", 4'd0, 1'b1, 4);

        waitOk = 1'b0;
        for (int i = 0; i < 40 && !waitOk; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            waitOk = drop_req;
        end
        checkOutput("wait_req_before_reset", int'(waitOk), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset_drop_req", int'(drop_req), 0);
        checkOutput("async_reset_active", int'(active), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        rEn = 1'b1; rSoft = 1'b0; rLanded = 1'b0; rLevel = 4'd0;
        for (int i = 0; i < 4000; i++) begin
            rEn      = ($urandom_range(99) >= 2);
            rPause   = ($urandom_range(99) < 10);
            rRestart = ($urandom_range(99) < 3);
            rAck     = ($urandom_range(99) < 25);
            if ($urandom_range(99) < 8)  rSoft = ~rSoft;
            if ($urandom_range(99) < 10) rLanded = ~rLanded;
            if ($urandom_range(99) < 5)  rLevel = 4'($urandom_range(15));
            applyStimulus(rEn, rPause, rSoft, rRestart, rAck, rLanded, rLevel);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
